// File: rtl/ritc_sample_readout_controller.sv
// RITC sample readout controller.
// Streams one header word plus 256 RAM words of a completed event buffer
// through a valid/ready port. A 4-deep output FIFO absorbs RAM latency.
// Reads are issued only while FIFO occupancy plus reads in flight is below
// the depth, so the FIFO cannot overflow.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a completed buffer while enable_i is high
// HEADER   | push the header word {event_count, rd_buf} into the FIFO
// READ     | issue RAM reads for word index 0..255
// DRAIN    | wait until every word is captured and accepted downstream
// CLEAR    | one-cycle clear_o pulse; event counter increments
// HOLDOFF  | one cycle so that the advanced read_buffer_i is visible
module ritc_sample_readout_controller #(
  parameter int          DATA_WIDTH        = 48,
  parameter int          RAM_LATENCY       = 2,
  parameter logic [15:0] EVENT_COUNT_RESET = 16'h0000
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic                  abort_i,
  input  logic [1:0]            write_buffer_i,
  input  logic [1:0]            read_buffer_i,
  output logic [9:0]            read_addr_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic                  clear_o,
  output logic                  busy_o,
  output logic [15:0]           event_count_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;
  localparam logic [2:0] S_HOLDOFF = 3'd5;

  logic [2:0]            r_state;
  logic [1:0]            r_rd_buf;
  logic [7:0]            r_idx;
  logic [15:0]           r_event_count;
  logic [1:0]            r_pipe;
  logic [2:0]            r_inflight;
  logic [DATA_WIDTH-1:0] r_fifo [0:3];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_count;

  logic                  w_available;
  logic                  w_space;
  logic                  w_read_en;
  logic                  w_capture;
  logic                  w_pop;
  logic                  w_header_push;
  logic                  w_push;
  logic                  w_clear;
  logic [DATA_WIDTH-1:0] w_header;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [2:0]            w_state_nxt;

  assign w_available   = (read_buffer_i != write_buffer_i);
  assign w_space       = (({1'b0, r_count} + {1'b0, r_inflight}) < 4'd4);
  assign w_read_en     = (r_state == S_READ) && w_space && !abort_i;
  // The pipe is always two bits; latency 1 simply taps the first stage.
  assign w_capture     = r_pipe[RAM_LATENCY-1];
  assign w_pop         = (r_count != 3'd0) && dout_ready_i;
  assign w_header_push = (r_state == S_HEADER) && w_space && !abort_i;
  assign w_push        = w_header_push || w_capture;
  assign w_clear       = (r_state == S_CLEAR) && !abort_i;
  assign w_header      = {{(DATA_WIDTH-18){1'b0}}, r_event_count, r_rd_buf};
  assign w_push_data   = w_header_push ? w_header : ram_data_i;

  assign read_addr_o   = {r_rd_buf, r_idx};
  assign read_en_o     = w_read_en;
  assign dout_valid_o  = (r_count != 3'd0);
  assign dout_o        = dout_valid_o ? r_fifo[r_rd_ptr] : '0;
  assign clear_o       = w_clear;
  assign busy_o        = (r_state != S_IDLE);
  assign event_count_o = r_event_count;

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_available && enable_i) w_state_nxt = S_HEADER;
      S_HEADER:  if (w_space) w_state_nxt = S_READ;
      S_READ:    if (w_read_en && (r_idx == 8'hFF)) w_state_nxt = S_DRAIN;
      // Leave as the last word is accepted so clear_o follows the final handshake.
      S_DRAIN:   if ((r_inflight == 3'd0) &&
                     ((r_count == 3'd0) || ((r_count == 3'd1) && w_pop)))
                   w_state_nxt = S_CLEAR;
      S_CLEAR:   w_state_nxt = S_HOLDOFF;
      S_HOLDOFF: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (abort_i) w_state_nxt = S_IDLE;
  end

  // State, buffer latch, word index and completed-event counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= S_IDLE;
      r_rd_buf      <= 2'd0;
      r_idx         <= 8'd0;
      r_event_count <= EVENT_COUNT_RESET;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && (w_state_nxt == S_HEADER)) begin
        r_rd_buf <= read_buffer_i;
        r_idx    <= 8'd0;
      end else if (w_read_en) begin
        r_idx <= r_idx + 8'd1;
      end
      if (w_clear) r_event_count <= r_event_count + 16'd1;
    end
  end

  // Read-return pipeline and in-flight count; abort drops late RAM returns.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pipe     <= 2'b00;
      r_inflight <= 3'd0;
    end else if (abort_i) begin
      r_pipe     <= 2'b00;
      r_inflight <= 3'd0;
    end else begin
      r_pipe     <= {r_pipe[0], w_read_en};
      r_inflight <= r_inflight + {2'b00, w_read_en} - {2'b00, w_capture};
    end
  end

  // Output FIFO: header and captured RAM words in, head word out on handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else if (abort_i) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_push_data;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

endmodule

// File: tb/tb_ritc_sample_readout_controller.sv
// Bench for ritc_sample_readout_controller. Two instances share stimulus:
// dut1 uses RAM latency 1 and an event counter reset value of 0xFFFF,
// dut2 uses the default latency 2 and counter reset 0. Expected words are
// queued when an event is started and popped on every output handshake.
module tb_ritc_sample_readout_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  wbuf = 2'd0;
  logic [1:0]  rbuf = 2'd0;
  logic        ready = 1'b1;

  logic [9:0]  addr1, addr2, r2a;
  logic        en1, en2, valid1, valid2, clear1, clear2, busy1, busy2;
  logic [47:0] ram1, ram2, dout1, dout2, exp1, exp2, hold1, hold2;
  logic [15:0] cnt1, cnt2;
  logic [15:0] ec1 = 16'hFFFF;
  logic [15:0] ec2 = 16'h0000;

  logic [47:0] q1[$];
  logic [47:0] q2[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_start = 0;
  int clr_cnt1 = 0, clr_cnt2 = 0, clr_cyc1 = 0, clr_cyc2 = 0;
  int acc1 = 0, acc2 = 0;
  bit stall1 = 0, stall2 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ritc_sample_readout_controller #(
    .DATA_WIDTH(48), .RAM_LATENCY(1), .EVENT_COUNT_RESET(16'hFFFF)
  ) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .abort_i(abort),
    .write_buffer_i(wbuf), .read_buffer_i(rbuf), .read_addr_o(addr1),
    .read_en_o(en1), .ram_data_i(ram1), .dout_o(dout1), .dout_valid_o(valid1),
    .dout_ready_i(ready), .clear_o(clear1), .busy_o(busy1), .event_count_o(cnt1)
  );

  ritc_sample_readout_controller #(
    .DATA_WIDTH(48), .RAM_LATENCY(2), .EVENT_COUNT_RESET(16'h0000)
  ) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .abort_i(abort),
    .write_buffer_i(wbuf), .read_buffer_i(rbuf), .read_addr_o(addr2),
    .read_en_o(en2), .ram_data_i(ram2), .dout_o(dout2), .dout_valid_o(valid2),
    .dout_ready_i(ready), .clear_o(clear2), .busy_o(busy2), .event_count_o(cnt2)
  );

  // RAM models return their own address, with one and two register stages.
  always @(posedge clk) begin
    ram1 <= {38'b0, addr1};
    r2a  <= addr2;
    ram2 <= {38'b0, r2a};
  end

  // dut1 scoreboard, stall stability, clear pulses and FIFO bound.
  always @(negedge clk) begin
    if (valid1 && ready) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_errors++;
        $display("FAIL dut1_stream: got %h, nothing expected", dout1);
      end else begin
        exp1 = q1.pop_front();
        if (dout1 !== exp1) begin
          n_errors++;
          $display("FAIL dut1_stream: got %h expected %h", dout1, exp1);
        end
      end
      acc1++;
    end
    if (stall1 && reset_n) begin
      n_checks++;
      if (valid1 !== 1'b1 || dout1 !== hold1) begin
        n_errors++;
        $display("FAIL dut1_stall: valid %b dout %h expected valid 1 dout %h", valid1, dout1, hold1);
      end
    end
    stall1 = valid1 && !ready && !abort && reset_n;
    hold1  = dout1;
    if (clear1) begin clr_cnt1++; clr_cyc1 = cyc; end
    n_checks++;
    if (dut1.r_count > 3'd4) begin
      n_errors++;
      $display("FAIL dut1_fifo_bound: count %0d expected <= 4", dut1.r_count);
    end
  end

  // dut2 scoreboard, stall stability, clear pulses and FIFO bound.
  always @(negedge clk) begin
    if (valid2 && ready) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_errors++;
        $display("FAIL dut2_stream: got %h, nothing expected", dout2);
      end else begin
        exp2 = q2.pop_front();
        if (dout2 !== exp2) begin
          n_errors++;
          $display("FAIL dut2_stream: got %h expected %h", dout2, exp2);
        end
      end
      acc2++;
    end
    if (stall2 && reset_n) begin
      n_checks++;
      if (valid2 !== 1'b1 || dout2 !== hold2) begin
        n_errors++;
        $display("FAIL dut2_stall: valid %b dout %h expected valid 1 dout %h", valid2, dout2, hold2);
      end
    end
    stall2 = valid2 && !ready && !abort && reset_n;
    hold2  = dout2;
    if (clear2) begin clr_cnt2++; clr_cyc2 = cyc; end
    n_checks++;
    if (dut2.r_count > 3'd4) begin
      n_errors++;
      $display("FAIL dut2_fifo_bound: count %0d expected <= 4", dut2.r_count);
    end
  end

  function automatic logic [47:0] hdr(input logic [15:0] c, input logic [1:0] b);
    return {30'b0, c, b};
  endfunction

  task automatic push_event(input logic [1:0] b);
    logic [7:0] w;
    q1.push_back(hdr(ec1, b));
    q2.push_back(hdr(ec2, b));
    for (int i = 0; i < 256; i++) begin
      w = i[7:0];
      q1.push_back({38'b0, b, w});
      q2.push_back({38'b0, b, w});
    end
  endtask

  // Pulse enable for one edge, then check header and first-read latency.
  task automatic start_event();
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    t_start = cyc;
    @(negedge clk);
    n_checks++;
    if (valid1 !== 1'b0 || valid2 !== 1'b0) begin
      n_errors++;
      $display("FAIL start_early_valid: valid1 %b valid2 %b expected 0 0", valid1, valid2);
    end
    @(negedge clk);
    n_checks++;
    if (valid1 !== 1'b1 || valid2 !== 1'b1 || en1 !== 1'b1 || en2 !== 1'b1) begin
      n_errors++;
      $display("FAIL start_latency: valid %b%b read_en %b%b expected 11 11", valid1, valid2, en1, en2);
    end
  endtask

  task automatic wait_done(input bit fixed_ready, input bit rnd);
    int  c1 = clr_cnt1;
    int  c2 = clr_cnt2;
    int  k = 0;
    bit  done = 0;
    while (!done && k < 4000) begin
      @(posedge clk); #1;
      if (rnd) ready = ($urandom_range(0, 1) == 1);
      k++;
      done = (clr_cnt1 > c1) && (clr_cnt2 > c2) && !busy1 && !busy2;
    end
    ready = 1'b1;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL event_timeout: clears %0d/%0d busy %b%b expected both done", clr_cnt1 - c1, clr_cnt2 - c2, busy1, busy2);
    end
    ec1 = ec1 + 16'd1;
    ec2 = ec2 + 16'd1;
    n_checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_errors++;
      $display("FAIL event_words: left %0d/%0d expected 0/0", q1.size(), q2.size());
    end
    n_checks++;
    if (cnt1 !== ec1 || cnt2 !== ec2) begin
      n_errors++;
      $display("FAIL event_count: got %h/%h expected %h/%h", cnt1, cnt2, ec1, ec2);
    end
    n_checks++;
    if (clr_cnt1 != c1 + 1 || clr_cnt2 != c2 + 1) begin
      n_errors++;
      $display("FAIL clear_pulses: got %0d/%0d expected 1/1", clr_cnt1 - c1, clr_cnt2 - c2);
    end
    if (fixed_ready) begin
      n_checks++;
      if (clr_cyc1 - t_start != 259 || clr_cyc2 - t_start != 260) begin
        n_errors++;
        $display("FAIL clear_timing: got %0d/%0d expected 259/260", clr_cyc1 - t_start, clr_cyc2 - t_start);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (en1 !== 1'b0 || valid1 !== 1'b0 || clear1 !== 1'b0 || busy1 !== 1'b0 ||
        dout1 !== 48'h0 || addr1 !== 10'h0 || cnt1 !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL reset_dut1: en %b v %b clr %b busy %b dout %h addr %h cnt %h expected zeros cnt ffff",
               en1, valid1, clear1, busy1, dout1, addr1, cnt1);
    end
    n_checks++;
    if (en2 !== 1'b0 || valid2 !== 1'b0 || clear2 !== 1'b0 || busy2 !== 1'b0 ||
        dout2 !== 48'h0 || addr2 !== 10'h0 || cnt2 !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_dut2: en %b v %b clr %b busy %b dout %h addr %h cnt %h expected zeros",
               en2, valid2, clear2, busy2, dout2, addr2, cnt2);
    end
  endtask

  task automatic test_idle_equal();
    bit bad = 0;
    wbuf = 2'd0; rbuf = 2'd0; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en1 || en2 || valid1 || valid2 || clear1 || clear2 || busy1 || busy2) bad = 1;
    end
    enable = 1'b0;
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL idle_equal: activity seen with equal buffers, expected none");
    end
  endtask

  task automatic test_wrap_buf3();
    wbuf = 2'd0; rbuf = 2'd3; ready = 1'b1;
    push_event(2'd3);
    start_event();
    wait_done(1, 0);
    n_checks++;
    if (cnt1 !== 16'h0000) begin
      n_errors++;
      $display("FAIL wrap_count: got %h expected 0000", cnt1);
    end
  endtask

  task automatic test_basic();
    wbuf = 2'd1; rbuf = 2'd0; ready = 1'b1;
    push_event(2'd0);
    start_event();
    wait_done(1, 0);
  endtask

  task automatic test_random_ready();
    wbuf = 2'd1; rbuf = 2'd0;
    push_event(2'd0);
    start_event();
    wait_done(0, 1);
  endtask

  task automatic test_abort();
    int base;
    int k = 0;
    int c1 = clr_cnt1;
    int c2 = clr_cnt2;
    wbuf = 2'd1; rbuf = 2'd0; ready = 1'b1;
    push_event(2'd0);
    start_event();
    base = acc2 - 1;
    while (acc2 < base + 101 && k < 1000) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (acc2 < base + 101) begin
      n_errors++;
      $display("FAIL abort_reach: accepted %0d expected 101", acc2 - base);
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    n_checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_idle: busy %b%b expected 00", busy1, busy2);
    end
    q1.delete(); q2.delete();
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (valid1 !== 1'b0 || valid2 !== 1'b0 || clr_cnt1 != c1 || clr_cnt2 != c2 ||
        cnt1 !== ec1 || cnt2 !== ec2) begin
      n_errors++;
      $display("FAIL abort_quiet: valid %b%b clears %0d/%0d cnt %h/%h expected 00 0/0 %h/%h",
               valid1, valid2, clr_cnt1 - c1, clr_cnt2 - c2, cnt1, cnt2, ec1, ec2);
    end
    push_event(2'd0);
    start_event();
    wait_done(1, 0);
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    wbuf = 2'd0; rbuf = 2'd1; ready = 1'b1;
    push_event(2'd1);
    start_event();
    repeat (60) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    ec1 = 16'hFFFF; ec2 = 16'h0000;
    q1.delete(); q2.delete();
    test_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid1 || valid2 || en1 || en2 || busy1 || busy2) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL reset_stale: activity after release, expected none");
    end
    push_event(2'd1);
    start_event();
    wait_done(1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_idle_equal();
    test_wrap_buf3();
    test_basic();
    test_random_ready();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ritc_sample_readout_controller.md
# ritc_sample_readout_controller

Sequences readout of completed 256-entry event buffers from the RITC sample storage RAM. It sits between the sample storage address generator and the downstream event packer. It watches the writer/reader buffer indices and, when a completed buffer exists, streams a header word followed by 256 RAM words through a valid/ready interface. On completion it pulses the buffer-clear strobe that advances the storage read buffer.

## Interface
Parameters:
- DATA_WIDTH, 48, RAM read word width; must be ≥ 18.
- RAM_LATENCY, 2, cycles from read_en_o/read_addr_o to valid ram_data_i; legal values 1 or 2.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  permits starting a new event readout.
- abort_i  input  1  synchronous abort of the current readout.
- write_buffer_i  input  2  buffer currently being written by the storage address generator.
- read_buffer_i  input  2  buffer currently designated for reading.
- read_addr_o  output  10  RAM read address: {read_buffer_i, word index[7:0]}.
- read_en_o  output  1  RAM read strobe.
- ram_data_i  input  DATA_WIDTH  RAM read data, valid RAM_LATENCY cycles after read_en_o.
- dout_o  output  DATA_WIDTH  output word.
- dout_valid_o  output  1  output word valid.
- dout_ready_i  input  1  downstream accepts dout_o.
- clear_o  output  1  one-cycle buffer-clear pulse; drives the storage block's clear input.
- busy_o  output  1  high whenever the state is not IDLE.
- event_count_o  output  16  count of completed events; wraps modulo 2^16.

## Operation
- available = (read_buffer_i != write_buffer_i). Equal indices mean no completed buffer.
- States: IDLE, HEADER, READ, DRAIN, CLEAR, HOLDOFF.
- IDLE: if available && enable_i, go to HEADER and latch the buffer index into rd_buf.
- HEADER: push header word {zeros, event_count_o[15:0], rd_buf[1:0]} into the output FIFO (LSB-aligned). Go to READ when FIFO space is available.
- READ: issue reads at word index 0..255 with read_addr_o = {rd_buf, idx}. Go to DRAIN after issuing idx 255.
- Read issue rule: read_en_o may assert only when fifo_count + inflight < 4. The output FIFO depth is 4. inflight counts reads issued but not yet captured.
- Capture: a RAM_LATENCY-deep shift register of read_en_o writes ram_data_i into the FIFO. The FIFO never overflows.
- DRAIN: wait until the FIFO is empty and inflight is 0 (all 257 words accepted), then go to CLEAR.
- CLEAR: assert clear_o for exactly one cycle, increment event_count_o, and go to HOLDOFF.
- HOLDOFF: one cycle so the updated read_buffer_i is visible, then go to IDLE.
- enable_i low mid-event: the current event completes normally. No new event starts.
- abort_i in any non-IDLE state: next state is IDLE.
  - The FIFO, inflight counter and read pipeline are flushed; late RAM returns are discarded.
  - No clear_o, no event_count_o increment.
  - The same buffer is re-read on the next start.
- abort_i has priority over every other transition. abort_i in the CLEAR cycle suppresses the pulse.
- Wrap-around: idx is 8 bits with no carry into the buffer bits. event_count_o rolls over from 0xFFFF to 0x0000.
- dout_o/dout_valid_o come from the FIFO head. A word is consumed when dout_valid_o && dout_ready_i.

## Timing
- Reset values: state IDLE, read_addr_o 0, read_en_o 0, dout_o 0, dout_valid_o 0, clear_o 0, busy_o 0, event_count_o 0. FIFO empty, inflight 0.
- Start latency: available && enable_i sampled in IDLE at cycle N gives HEADER at N+1 and dout_valid_o high at N+2 (header word).
- First read_en_o at cycle N+2. First data word on dout_o no earlier than N+3+RAM_LATENCY.
- With dout_ready_i held high: one word per cycle sustained, no bubbles after the first data word.
- Event duration with ready held high: 257 output cycles plus RAM_LATENCY plus 4 (start, CLEAR, HOLDOFF).
- With dout_ready_i low: read issue stalls within 4 words; dout_o and dout_valid_o hold stable.
- clear_o asserts the cycle after the final handshake. The earliest next HEADER is 3 cycles after clear_o.

## Test plan
- Buffers 00/00 with enable_i high → stays IDLE; read_en_o, dout_valid_o and clear_o stay 0.
- Set write_buffer_i=01, read_buffer_i=00, ready held high, RAM returning its address → header 0x0000_0 then data 0x000..0x0FF in order, exactly 257 words. Then one clear_o pulse; event_count_o becomes 1.
- Same as above with dout_ready_i randomly toggled at 50% → identical ordered stream with no drops or duplicates; dout_o stable while stalled; FIFO never exceeds 4.
- abort_i at data word 100 → returns to IDLE with no clear_o; with the buffers unchanged, it restarts with header count 0 and data from address 0.
- Preload event_count_o to 0xFFFF, complete one event with read_buffer_i=11 → header {0xFFFF, 2'b11}; event_count_o becomes 0x0000.
- reset_n_i low mid-READ with RAM_LATENCY=1 and =2 → all outputs go to reset values immediately (asynchronous); no stale data appears after release.
